// File: rtl/cdb_arbiter_rr.sv
// Purpose: picks one FU result per cycle (round-robin or fixed priority) and broadcasts it on the CDB.
// Latency: grant is combinational; the broadcast appears one cycle after the grant.
// Backpressure: stall_i or rst suppress every grant, so no FU pops its head and nothing is broadcast.
module cdb_arbiter_rr #(
  parameter int N_FU       = 3,
  parameter int TAG_W      = 4,
  parameter int DATA_W     = 32,
  parameter int TID_W      = 1,
  parameter int FIXED_PRIO = 0,
  localparam int SRC_W     = (N_FU > 1) ? $clog2(N_FU) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_i,
  input  logic [N_FU-1:0]         fu_req,
  input  logic [N_FU*TAG_W-1:0]   fu_tag,
  input  logic [N_FU*DATA_W-1:0]  fu_value,
  input  logic [N_FU*TID_W-1:0]   fu_tid,
  output logic [N_FU-1:0]         fu_gnt,
  input  logic                    flush_i,
  input  logic [TID_W-1:0]        flush_tid,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [DATA_W-1:0]       cdb_value,
  output logic [TID_W-1:0]        cdb_tid,
  output logic [SRC_W-1:0]        cdb_src
);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] value;
    logic [TID_W-1:0]  tid;
    logic [SRC_W-1:0]  src;
  } cdb_t;

  logic [N_FU-1:0]  w_elig;
  logic [N_FU-1:0]  w_gnt;
  logic             w_found;
  logic [SRC_W-1:0] w_win;
  logic [SRC_W-1:0] w_sel;
  int               w_idx;
  logic [SRC_W-1:0] w_ptr_nxt;
  cdb_t             w_nxt;

  logic [SRC_W-1:0] r_ptr;
  logic             r_valid;
  cdb_t             r_cdb;

  // Requests from a thread being squashed this cycle are not eligible.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < N_FU; i++) begin
      w_elig[i] = fu_req[i] & ~(flush_i & (fu_tid[i*TID_W +: TID_W] == flush_tid));
    end
  end

  // Search from the pointer (or from 0 in fixed priority) for the first eligible FU.
  always_comb begin
    w_gnt   = '0;
    w_found = 1'b0;
    w_win   = '0;
    w_sel   = '0;
    w_idx   = 0;
    if (!rst && !stall_i) begin
      for (int k = 0; k < N_FU; k++) begin
        w_idx = (FIXED_PRIO != 0) ? k : int'(r_ptr) + k;
        if (w_idx >= N_FU) w_idx = w_idx - N_FU;
        w_sel = SRC_W'(w_idx);
        if (!w_found && w_elig[w_sel]) begin
          w_found      = 1'b1;
          w_gnt[w_sel] = 1'b1;
          w_win        = w_sel;
        end
      end
    end
  end

  // Pointer moves past the winner; it is pinned to 0 in fixed priority or with a single FU.
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_found) begin
      if (FIXED_PRIO != 0 || w_win == SRC_W'(N_FU - 1)) w_ptr_nxt = '0;
      else                                               w_ptr_nxt = w_win + 1'b1;
    end
  end

  // Winner's head fields as they will be loaded into the broadcast register.
  always_comb begin
    w_nxt       = '0;
    w_nxt.tag   = fu_tag[w_win*TAG_W +: TAG_W];
    w_nxt.value = fu_value[w_win*DATA_W +: DATA_W];
    w_nxt.tid   = fu_tid[w_win*TID_W +: TID_W];
    w_nxt.src   = w_win;
  end

  // Arbitration pointer; holds when nothing is granted (stall, no requests, full squash).
  always_ff @(posedge clk) begin
    if (rst) r_ptr <= '0;
    else     r_ptr <= w_ptr_nxt;
  end

  // Broadcast register: valid only for the cycle after a grant, data holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_cdb   <= '0;
    end else begin
      r_valid <= w_found;
      if (w_found) r_cdb <= w_nxt;
    end
  end

  assign fu_gnt    = w_gnt;
  // An in-flight broadcast of a squashed thread is killed in the same cycle.
  assign cdb_valid = r_valid & ~(flush_i & (r_cdb.tid == flush_tid));
  assign cdb_tag   = r_cdb.tag;
  assign cdb_value = r_cdb.value;
  assign cdb_tid   = r_cdb.tid;
  assign cdb_src   = r_cdb.src;

endmodule

// File: tb/tb_cdb_arbiter_rr.sv
module tb_cdb_arbiter_rr;

  localparam int N_FU   = 3;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;
  localparam int TID_W  = 1;
  localparam int SRC_W  = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   stall_i;
  logic [N_FU-1:0]        fu_req;
  logic [N_FU*TAG_W-1:0]  fu_tag;
  logic [N_FU*DATA_W-1:0] fu_value;
  logic [N_FU*TID_W-1:0]  fu_tid;
  logic                   flush_i;
  logic [TID_W-1:0]       flush_tid;

  logic [N_FU-1:0]        a_gnt,   b_gnt;
  logic                   a_valid, b_valid;
  logic [TAG_W-1:0]       a_tag,   b_tag;
  logic [DATA_W-1:0]      a_value, b_value;
  logic [TID_W-1:0]       a_tid,   b_tid;
  logic [SRC_W-1:0]       a_src,   b_src;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cdb_arbiter_rr #(.N_FU(N_FU), .TAG_W(TAG_W), .DATA_W(DATA_W), .TID_W(TID_W), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst(rst), .stall_i(stall_i), .fu_req(fu_req), .fu_tag(fu_tag),
    .fu_value(fu_value), .fu_tid(fu_tid), .fu_gnt(a_gnt), .flush_i(flush_i),
    .flush_tid(flush_tid), .cdb_valid(a_valid), .cdb_tag(a_tag), .cdb_value(a_value),
    .cdb_tid(a_tid), .cdb_src(a_src)
  );

  cdb_arbiter_rr #(.N_FU(N_FU), .TAG_W(TAG_W), .DATA_W(DATA_W), .TID_W(TID_W), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst(rst), .stall_i(stall_i), .fu_req(fu_req), .fu_tag(fu_tag),
    .fu_value(fu_value), .fu_tid(fu_tid), .fu_gnt(b_gnt), .flush_i(flush_i),
    .flush_tid(flush_tid), .cdb_valid(b_valid), .cdb_tag(b_tag), .cdb_value(b_value),
    .cdb_tid(b_tid), .cdb_src(b_src)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; fu_req = 3'b111; flush_i = 1'b0; flush_tid = '0;
    fu_tag   = {4'h3, 4'h2, 4'h1};
    fu_value = {32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
    fu_tid   = 3'b000;
    #1;

    // Reset: no grant while rst is high, then everything cleared.
    for (int c = 0; c < 2; c++) begin
      #2; chk("rst_gnt", 64'(a_gnt), 64'h0);
      tick();
    end
    rst = 1'b0; fu_req = 3'b000;
    #2;
    chk("rst_valid", 64'(a_valid), 64'h0);
    chk("rst_tag",   64'(a_tag),   64'h0);
    chk("rst_value", 64'(a_value), 64'h0);
    chk("rst_tid",   64'(a_tid),   64'h0);
    chk("rst_src",   64'(a_src),   64'h0);
    chk("rst_gnt0",  64'(a_gnt),   64'h0);
    tick();

    // Round-robin fairness with all FUs requesting.
    fu_req = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #2; chk("rr_gnt", 64'(a_gnt), 64'(3'b001 << (c % 3)));
      tick();
      chk("rr_src",   64'(a_src),   64'(c % 3));
      chk("rr_valid", 64'(a_valid), 64'h1);
    end

    // Skip and wrap: ptr=0 now.
    fu_req = 3'b011; #2; chk("sk_gnt_a", 64'(a_gnt), 64'h1); tick();
    fu_req = 3'b011; #2; chk("sk_gnt_b", 64'(a_gnt), 64'h2); tick();
    fu_req = 3'b011; #2; chk("sk_gnt_c", 64'(a_gnt), 64'h1); tick();
    fu_req = 3'b010; #2; chk("sk_gnt_d", 64'(a_gnt), 64'h2); tick();

    // Data path: FU1 carries a distinctive result.
    fu_tag[4 +: 4]    = 4'h5;
    fu_value[32 +: 32] = 32'hDEADBEEF;
    fu_tid[1]         = 1'b1;
    fu_req = 3'b010; #2; chk("dt_gnt", 64'(a_gnt), 64'h2);
    tick();
    fu_req = 3'b000;
    chk("dt_valid", 64'(a_valid), 64'h1);
    chk("dt_tag",   64'(a_tag),   64'h5);
    chk("dt_value", 64'(a_value), 64'hDEADBEEF);
    chk("dt_tid",   64'(a_tid),   64'h1);
    chk("dt_src",   64'(a_src),   64'h1);
    #2; chk("dt_gnt_idle", 64'(a_gnt), 64'h0);
    tick();
    chk("dt_valid_off", 64'(a_valid), 64'h0);
    chk("dt_tag_hold",  64'(a_tag),   64'h5);

    // Stall with ptr=1 (reached by a grant to FU0 from ptr=2).
    fu_req = 3'b001; #2; chk("st_pre_gnt", 64'(a_gnt), 64'h1); tick();
    stall_i = 1'b1; fu_req = 3'b111;
    for (int c = 0; c < 3; c++) begin
      #2; chk("st_gnt", 64'(a_gnt), 64'h0);
      tick();
      chk("st_valid", 64'(a_valid), 64'h0);
    end
    stall_i = 1'b0;
    #2; chk("st_resume_gnt", 64'(a_gnt), 64'h2);
    tick();
    chk("st_resume_src", 64'(a_src), 64'h1);

    // Fixed priority with thread squash.
    fu_tid = 3'b010; fu_req = 3'b011;
    #2; chk("fp_gnt", 64'(b_gnt), 64'h1);
    tick();
    chk("fp_tid_raw", 64'(b_tid), 64'h0);
    chk("fp_valid_pre", 64'(b_valid), 64'h1);
    flush_i = 1'b1; flush_tid = 1'b0;
    #2;
    chk("fl_gnt_fp",   64'(b_gnt),   64'h2);
    chk("fl_valid_fp", 64'(b_valid), 64'h0);
    chk("fl_gnt_rr",   64'(a_gnt),   64'h2);
    tick();
    chk("fl_src_fp",   64'(b_src),   64'h1);
    chk("fl_valid_t1", 64'(b_valid), 64'h1);
    flush_i = 1'b0; fu_req = 3'b110;
    #2; chk("fp_gnt_low", 64'(b_gnt), 64'h2);

    // Reset in the middle of traffic suppresses the grant.
    rst = 1'b1; fu_req = 3'b111;
    #1; chk("rst_mid_gnt", 64'(a_gnt), 64'h0);
    tick();
    chk("rst_mid_valid", 64'(a_valid), 64'h0);
    chk("rst_mid_src",   64'(a_src),   64'h0);
    rst = 1'b0;
    #2; chk("rst_mid_ptr0", 64'(a_gnt), 64'h1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
